// File: rtl/tile_spawner.sv
// Tile spawner: places one new "2" or "4" tile in a random empty board cell,
// retrying random positions a few times before falling back to a linear scan.
module tile_spawner #(
    parameter int MAX_TRIES = 4,
    parameter int FOUR_CNT  = 2
) (
    input  logic        clk,
    input  logic        reset_n_debounced,
    input  logic        spawn_req,
    input  logic [15:0] empty_mask,
    input  logic [3:0]  rnd_pos,
    input  logic [3:0]  rnd_val,
    output logic        rnd_get,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [3:0]  wr_tile,
    output logic        busy,
    output logic        no_space
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GET   = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] SCAN  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    localparam logic [4:0] MAX_TRIES_W = 5'(MAX_TRIES);
    localparam logic [4:0] FOUR_CNT_W  = 5'(FOUR_CNT);

    logic [2:0]  state;
    logic [15:0] mask_q;
    logic [3:0]  try_cnt;
    logic [3:0]  scan_idx;
    logic [3:0]  tile_q;
    logic [3:0]  addr_q;
    logic [3:0]  wr_tile_q;
    logic        no_space_q;
    logic [3:0]  check_tile;
    logic        retry_ok;

    assign check_tile = ({1'b0, rnd_val} < FOUR_CNT_W) ? 4'd2 : 4'd1;
    assign retry_ok   = ({1'b0, try_cnt} + 5'd1) < MAX_TRIES_W;

    // addr_q and wr_tile_q only change on entry to WRITE, so the write port
    // keeps showing the last written cell between operations.
    always_ff @(posedge clk or negedge reset_n_debounced) begin
        if (!reset_n_debounced) begin
            state      <= IDLE;
            mask_q     <= 16'd0;
            try_cnt    <= 4'd0;
            scan_idx   <= 4'd0;
            tile_q     <= 4'd0;
            addr_q     <= 4'd0;
            wr_tile_q  <= 4'd0;
            no_space_q <= 1'b0;
        end else begin
            no_space_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        mask_q  <= empty_mask;
                        try_cnt <= 4'd0;
                        if (empty_mask == 16'd0) begin
                            no_space_q <= 1'b1;
                        end else begin
                            state <= GET;
                        end
                    end
                end
                GET: begin
                    state <= CHECK;
                end
                CHECK: begin
                    tile_q <= check_tile;
                    if (mask_q[rnd_pos]) begin
                        addr_q    <= rnd_pos;
                        wr_tile_q <= check_tile;
                        state     <= WRITE;
                    end else if (retry_ok) begin
                        try_cnt <= try_cnt + 4'd1;
                        state   <= GET;
                    end else begin
                        scan_idx <= rnd_pos + 4'd1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (mask_q[scan_idx]) begin
                        addr_q    <= scan_idx;
                        wr_tile_q <= tile_q;
                        state     <= WRITE;
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rnd_get  = (state == GET);
    assign wr_en    = (state == WRITE);
    assign busy     = (state != IDLE);
    assign no_space = no_space_q;
    assign wr_addr  = addr_q;
    assign wr_tile  = wr_tile_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: directed scenarios plus randomized
// requests checked against a placement model built from the spawning rules.
module tb_tile_spawner;

    localparam int MT = 4;
    localparam int FC = 2;

    logic        clk;
    logic        reset_n_debounced;
    logic        spawn_req;
    logic [15:0] empty_mask;
    logic [3:0]  rnd_pos;
    logic [3:0]  rnd_val;
    logic        rnd_get;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_tile;
    logic        busy;
    logic        no_space;

    int tests_run;
    int tests_failed;

    logic [3:0] pos_seq [16];
    logic [3:0] val_seq [16];

    tile_spawner #(.MAX_TRIES(MT), .FOUR_CNT(FC)) dut (
        .clk               (clk),
        .reset_n_debounced (reset_n_debounced),
        .spawn_req         (spawn_req),
        .empty_mask        (empty_mask),
        .rnd_pos           (rnd_pos),
        .rnd_val           (rnd_val),
        .rnd_get           (rnd_get),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_tile           (wr_tile),
        .busy              (busy),
        .no_space          (no_space)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outcome of one request: random tries first, then a wrapping scan.
    function automatic void model(input logic [15:0] mask, output int gets, output int wr_cyc,
                                  output logic [3:0] addr, output logic [3:0] tile);
        gets   = 0;
        wr_cyc = 0;
        addr   = 4'd0;
        tile   = 4'd0;
        if (mask == 16'd0) return;
        for (int t = 0; t < MT; t++) begin
            gets = t + 1;
            tile = (int'(val_seq[t]) < FC) ? 4'd2 : 4'd1;
            if (mask[pos_seq[t]]) begin
                addr   = pos_seq[t];
                wr_cyc = 2 * gets + 1;
                return;
            end
        end
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (int'(pos_seq[MT-1]) + k) % 16;
            if (mask[idx]) begin
                addr   = 4'(idx);
                wr_cyc = 2 * MT + k + 1;
                return;
            end
        end
    endfunction

    task automatic do_spawn(input string name, input logic [15:0] mask,
                            input logic [15:0] mask_after, input bit poke_busy);
        int         exp_gets, exp_wr, last;
        logic [3:0] exp_addr, exp_tile;
        int         gets, wrs, wr_cyc, ns, ns_cyc, busy_err, excl_err;
        logic [3:0] got_addr, got_tile;
        model(mask, exp_gets, exp_wr, exp_addr, exp_tile);
        gets = 0; wrs = 0; wr_cyc = 0; ns = 0; ns_cyc = 0; busy_err = 0; excl_err = 0;
        got_addr = 4'd0; got_tile = 4'd0;
        rnd_pos    = 4'($urandom);
        rnd_val    = 4'($urandom);
        spawn_req  = 1'b1;
        empty_mask = mask;
        @(posedge clk); #1;
        spawn_req  = 1'b0;
        empty_mask = mask_after;
        last = (exp_wr > 0) ? exp_wr + 2 : 4;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (rnd_get === 1'b1) begin
                if (gets < 16) begin
                    rnd_pos = pos_seq[gets];
                    rnd_val = val_seq[gets];
                end
                gets++;
            end
            if (wr_en === 1'b1) begin
                wrs++;
                wr_cyc   = cyc;
                got_addr = wr_addr;
                got_tile = wr_tile;
            end
            if (no_space === 1'b1) begin
                ns++;
                ns_cyc = cyc;
            end
            if (busy !== 1'((exp_wr > 0) && (cyc <= exp_wr))) busy_err++;
            if (int'(rnd_get) + int'(wr_en) + int'(no_space) > 1) excl_err++;
            if (poke_busy && cyc == 2) begin
                spawn_req  = 1'b1;
                empty_mask = 16'hFFFF;
            end else if (poke_busy && cyc == 3) begin
                spawn_req  = 1'b0;
                empty_mask = mask_after;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (gets !== exp_gets) begin
            tests_failed++;
            $display("[TB] FAIL %s rnd_get pulses: got %0d expected %0d", name, gets, exp_gets);
        end
        tests_run++;
        if (wrs !== ((exp_wr > 0) ? 1 : 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s wr_en pulses: got %0d expected %0d", name, wrs, (exp_wr > 0) ? 1 : 0);
        end
        tests_run++;
        if (ns !== ((exp_wr > 0) ? 0 : 1) || (exp_wr == 0 && ns_cyc !== 1)) begin
            tests_failed++;
            $display("[TB] FAIL %s no_space: got %0d pulses at cycle %0d expected %0d", name, ns, ns_cyc,
                     (exp_wr > 0) ? 0 : 1);
        end
        tests_run++;
        if (busy_err !== 0 || excl_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s busy/exclusive: got %0d busy errors, %0d overlaps expected 0", name,
                     busy_err, excl_err);
        end
        if (exp_wr > 0) begin
            tests_run++;
            if (wr_cyc !== exp_wr || got_addr !== exp_addr || got_tile !== exp_tile) begin
                tests_failed++;
                $display("[TB] FAIL %s write: got cycle %0d addr %0d tile %0d expected cycle %0d addr %0d tile %0d",
                         name, wr_cyc, got_addr, got_tile, exp_wr, exp_addr, exp_tile);
            end
            tests_run++;
            if (wr_addr !== exp_addr || wr_tile !== exp_tile) begin
                tests_failed++;
                $display("[TB] FAIL %s hold: got addr %0d tile %0d expected addr %0d tile %0d", name,
                         wr_addr, wr_tile, exp_addr, exp_tile);
            end
        end
    endtask

    task automatic test_reset();
        reset_n_debounced = 1'b0;
        #2;
        tests_run++;
        if ({rnd_get, wr_en, no_space, busy, wr_addr, wr_tile} !== 12'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset outputs: got %b expected 0", {rnd_get, wr_en, no_space, busy, wr_addr, wr_tile});
        end
        repeat (2) @(posedge clk);
        #1 reset_n_debounced = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        for (int i = 0; i < 16; i++) begin pos_seq[i] = 4'd5; val_seq[i] = 4'd7; end
        do_spawn("direct_hit", 16'hFFFF, 16'hFFFF, 1'b0);
        pos_seq[0] = 4'd3; pos_seq[1] = 4'd0;
        for (int i = 0; i < 16; i++) val_seq[i] = 4'd1;
        do_spawn("four_retry", 16'h0001, 16'h0001, 1'b0);
        for (int i = 0; i < 16; i++) begin pos_seq[i] = 4'd14; val_seq[i] = 4'd9; end
        do_spawn("scan_wrap", 16'h0002, 16'h0002, 1'b0);
        do_spawn("full_board", 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin pos_seq[i] = 4'd9; val_seq[i] = 4'd0; end
        do_spawn("ignore_freeze", 16'hFFFF, 16'h0000, 1'b1);
    endtask

    task automatic test_abort();
        int wrs;
        logic [3:0] nibble;
        wrs = 0;
        for (int i = 0; i < 16; i++) begin pos_seq[i] = 4'd14; val_seq[i] = 4'd3; end
        spawn_req  = 1'b1;
        empty_mask = 16'h0002;
        @(posedge clk); #1;
        spawn_req = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            if (rnd_get === 1'b1) rnd_pos = 4'd14;
            @(posedge clk); #1;
        end
        reset_n_debounced = 1'b0;
        #2;
        tests_run++;
        if ({rnd_get, wr_en, no_space, busy, wr_addr, wr_tile} !== 12'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort outputs: got %b expected 0", {rnd_get, wr_en, no_space, busy, wr_addr, wr_tile});
        end
        repeat (2) @(posedge clk);
        #1 reset_n_debounced = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (wr_en === 1'b1 || busy === 1'b1) wrs++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (wrs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abort no write: got %0d active cycles expected 0", wrs);
        end
        nibble = 4'd6;
        for (int i = 0; i < 16; i++) begin pos_seq[i] = nibble; val_seq[i] = 4'd15; end
        do_spawn("after_abort", 16'h0040, 16'h0040, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) begin
                pos_seq[i] = 4'($urandom);
                val_seq[i] = 4'($urandom);
            end
            case ($urandom_range(0, 3))
                0:       mask = 16'($urandom);
                1:       mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       mask = 16'd1 << $urandom_range(0, 15);
                default: mask = (n % 7 == 0) ? 16'd0 : 16'($urandom) & 16'($urandom);
            endcase
            do_spawn("random", mask, 16'($urandom), (mask != 16'd0) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset_n_debounced = 1'b1;
        spawn_req         = 1'b0;
        empty_mask        = 16'd0;
        rnd_pos           = 4'd0;
        rnd_val           = 4'd0;
        test_reset();
        test_directed();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tile_spawner.md
TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 Parameter MAX_TRIES, default 4: random placement attempts before falling back to a linear scan (range 1..15).
REQ-002 Parameter FOUR_CNT, default 2: rnd_val values below FOUR_CNT produce a "4" tile; range 0..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n_debounced  input  1  asynchronous, active-low reset.
REQ-005 spawn_req  input  1  one-cycle request to place one new tile.
REQ-006 empty_mask  input  16  bit i = 1 means board cell i is empty.
REQ-007 rnd_pos  input  4  random cell index from the random generator; held between get pulses.
REQ-008 rnd_val  input  4  second random nibble from the random generator; held between get pulses.
REQ-009 rnd_get  output  1  one-cycle pulse requesting new random values; values are valid the cycle after the pulse.
REQ-010 wr_en  output  1  one-cycle board write strobe.
REQ-011 wr_addr  output  4  cell index written.
REQ-012 wr_tile  output  4  log2 tile code: 1 = "2", 2 = "4".
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 no_space  output  1  one-cycle pulse when a request finds no empty cell.

Function
REQ-015 The FSM SHALL have the states IDLE, GET, CHECK, SCAN and WRITE.
REQ-016 In IDLE, spawn_req=1 SHALL latch empty_mask into mask_q and clear try_cnt, all at the same edge.
- If empty_mask = 0 at that edge, the FSM SHALL stay in IDLE and pulse no_space in the next cycle.
- Otherwise, the FSM SHALL go to GET.
REQ-017 spawn_req SHALL be ignored while busy = 1; requests are not queued.
REQ-018 In GET, rnd_get SHALL be 1 for exactly one cycle; the next state is CHECK.
REQ-019 In CHECK, the block SHALL sample rnd_pos and rnd_val.
- If mask_q[rnd_pos] = 1: latch addr_q = rnd_pos and go to WRITE.
- Else if try_cnt + 1 < MAX_TRIES: increment try_cnt and go to GET.
- Else: load scan_idx = rnd_pos + 1 (mod 16) and go to SCAN.
REQ-020 In CHECK, tile_q SHALL be latched on every visit: 2 if rnd_val < FOUR_CNT, else 1.
REQ-021 In SCAN, the block SHALL test one cell per cycle.
- If mask_q[scan_idx] = 1: addr_q = scan_idx, go to WRITE.
- Else: scan_idx increments, wrapping 15 -> 0.
REQ-022 SCAN SHALL always terminate within 16 cycles, because mask_q is nonzero; SCAN SHALL never pulse rnd_get.
REQ-023 In WRITE, for one cycle: wr_en = 1, wr_addr = addr_q and wr_tile = tile_q; the next state is IDLE.
REQ-024 Outside WRITE, wr_en SHALL be 0 and wr_addr/wr_tile SHALL hold their last written values.
REQ-025 Latency from spawn_req to wr_en when the first random cell is empty SHALL be 3 cycles.
- spawn_req sampled at edge 0.
- GET in cycle 1.
- CHECK in cycle 2.
- wr_en in cycle 3.
REQ-026 Changes to empty_mask after acceptance SHALL NOT affect the operation in progress.
REQ-027 rnd_get, wr_en and no_space SHALL never be high simultaneously.
REQ-028 try_cnt SHALL be 4 bits wide; arithmetic on rnd_pos and scan_idx SHALL be modulo 16.

Reset
REQ-029 On reset_n_debounced = 0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-030 Reset values SHALL be: rnd_get = wr_en = no_space = busy = 0, wr_addr = 0, wr_tile = 0, mask_q = 0, try_cnt = 0, scan_idx = 0.
REQ-031 Reset asserted mid-operation SHALL abort without any write.
REQ-032 The first spawn_req accepted after reset release SHALL be handled normally.

Verification
REQ-033 Direct hit: empty_mask = 16'hFFFF, rnd_pos = 5, rnd_val = 7, FOUR_CNT = 2 -> rnd_get in cycle 1; wr_en in cycle 3 with wr_addr = 5, wr_tile = 1; busy = 1 for cycles 1-3.
REQ-034 Four tile and retry: empty_mask = 16'h0001, rnd_pos = 3 then 0, rnd_val = 1 -> two rnd_get pulses; wr_addr = 0, wr_tile = 2.
REQ-035 Scan fallback with wrap: empty_mask = 16'h0002, rnd_pos stuck at 14, MAX_TRIES = 4 -> four rnd_get pulses; SCAN visits 15, 0, 1; wr_addr = 1.
REQ-036 Full board: empty_mask = 0, spawn_req -> no_space pulse next cycle, busy stays 0, no rnd_get, no wr_en.
REQ-037 Ignore and mask freeze: spawn_req while busy, and empty_mask cleared to 0 after acceptance -> exactly one wr_en, using the latched mask.
REQ-038 Abort: reset_n_debounced low during SCAN -> all outputs 0 with no clock edge; no wr_en afterwards; the next spawn_req completes normally.
